sensor_abs_scheduler: RTL

//  Time-shares the single 8-bit absolute-value datapath among NCH sensor channels (blood, pressure, ...).

---
 rtl/health_monitor_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/sensor_abs_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/health_monitor_pkg.sv
// +----------------------------------------------------------------------------+
// | health_monitor_pkg                                                         |
// | Shared constants and scheduler state encoding for the health monitor.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package health_monitor_pkg;

  localparam int c_default_nch          = 4;
  localparam int c_default_w            = 8;
  localparam int c_default_alarm_thresh = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | Combinational round-robin pick starting one past the previous grant.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_last_grant,
  output logic [CW-1:0]  o_grant,
  output logic           o_any
);

  int w_idx;

  // Scan farthest offset first so the nearest requester after i_last_grant wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = NCH; k >= 1; k--) begin
      w_idx = (int'(i_last_grant) + k) % NCH;
      if (i_req[CW'(w_idx)]) begin
        o_grant = CW'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sensor_abs_scheduler.sv
// +----------------------------------------------------------------------------+
// | sensor_abs_scheduler                                                       |
// | Round-robin time-sharing of one external absolute-value unit among NCH     |
// | sensor channels; optional sticky alarms enabled by SCHED_ALARM_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sensor_abs_scheduler
  import health_monitor_pkg::*;
#(
  parameter  int NCH          = c_default_nch,
  parameter  int W            = c_default_w,
  parameter  int ALARM_THRESH = c_default_alarm_thresh,
  localparam int CW           = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] data,
  output logic [NCH-1:0]   ack,
  output logic [W-1:0]     abs_in,
  input  logic [W-1:0]     abs_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [CW-1:0]    res_ch,
  output logic [NCH-1:0]   alarm
);

  sched_state_t  r_state;
  sched_state_t  w_next;
  logic [CW-1:0] r_last_grant;
  logic [CW-1:0] w_grant;
  logic          w_any;
  logic [W-1:0]  w_sample;
  logic [W-1:0]  r_abs_in;
  logic [W-1:0]  r_res_data;
  logic [CW-1:0] r_res_ch;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  assign w_sample = data[int'(w_grant)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ack       = '0;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_CALC;
      ST_CALC: begin
        ack[r_last_grant] = 1'b1;
        w_next            = ST_RESP;
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_last_grant doubles as the in-flight channel while in CALC/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= CW'(NCH-1);
      r_abs_in     <= '0;
      r_res_data   <= '0;
      r_res_ch     <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_abs_in     <= w_sample;
        r_last_grant <= w_grant;
      end
      if (r_state == ST_CALC) begin
        r_res_data <= abs_out;
        r_res_ch   <= r_last_grant;
      end
    end
  end

  assign abs_in   = r_abs_in;
  assign res_data = r_res_data;
  assign res_ch   = r_res_ch;

`ifdef SCHED_ALARM_EN
  logic [NCH-1:0] r_alarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_alarm <= '0;
    else if (r_state == ST_CALC && abs_out > W'(ALARM_THRESH))
      r_alarm[r_last_grant] <= 1'b1;
  end

  assign alarm = r_alarm;
`else
  logic [W-1:0] w_unused_thresh;
  assign w_unused_thresh = W'(ALARM_THRESH);
  assign alarm           = '0;
`endif

endmodule

`default_nettype wire
